// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the integer register-file write port (ALU vs LSU, round-robin),
// with a registered write stage and a pending-write scoreboard for RAW stall detection.
module rf_wb_arbiter #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                alu_valid_i,
    output logic                alu_ready_o,
    input  logic [4:0]          alu_rd_i,
    input  logic [DATA_W-1:0]   alu_data_i,

    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [4:0]          lsu_rd_i,
    input  logic [DATA_W-1:0]   lsu_data_i,

    input  logic                set_en_i,
    input  logic [4:0]          set_rd_i,

    output logic                rf_wr_en_o,
    output logic [4:0]          rf_wrd_o,
    output logic [DATA_W-1:0]   rf_wdata_o,
    output logic [NUM_REGS-1:0] pending_o
);

    logic                prio_q, prio_d;
    logic                wr_en_q, wr_en_d;
    logic [4:0]          wrd_q, wrd_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic alu_gnt, lsu_gnt;

    // prio_q == 0 favours the ALU when both request; readys are held low during reset.
    always_comb begin
        alu_gnt = rst_n & alu_valid_i & (~lsu_valid_i | ~prio_q);
        lsu_gnt = rst_n & lsu_valid_i & (~alu_valid_i |  prio_q);
    end

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;

    always_comb begin
        prio_d  = prio_q;
        wr_en_d = 1'b0;
        wrd_d   = wrd_q;
        wdata_d = wdata_q;
        if (alu_gnt) begin
            prio_d  = 1'b1;
            wrd_d   = alu_rd_i;
            wdata_d = alu_data_i;
            wr_en_d = (alu_rd_i != 5'd0);
        end else if (lsu_gnt) begin
            prio_d  = 1'b0;
            wrd_d   = lsu_rd_i;
            wdata_d = lsu_data_i;
            wr_en_d = (lsu_rd_i != 5'd0);
        end
    end

    // Clear for the committing write first, then set, so a same-index set wins.
    // Bit 0 is never touched and stays at its reset value of 0.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en_q && (wrd_q == 5'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (set_en_i && (set_rd_i == 5'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wrd_q     <= 5'd0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wrd_q     <= wrd_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign rf_wr_en_o = wr_en_q;
    assign rf_wrd_o   = wrd_q;
    assign rf_wdata_o = wdata_q;
    assign pending_o  = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of the grant rule, write stage and pending bitmap.
module tb_rf_wb_arbiter;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, lsu_valid, set_en;
    logic              alu_ready, lsu_ready;
    logic [4:0]        alu_rd, lsu_rd, set_rd;
    logic [DATA_W-1:0] alu_data, lsu_data;
    logic              rf_wr_en;
    logic [4:0]        rf_wrd;
    logic [DATA_W-1:0] rf_wdata;
    logic [NUM_REGS-1:0] pending;

    rf_wb_arbiter #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid),
        .alu_ready_o (alu_ready),
        .alu_rd_i    (alu_rd),
        .alu_data_i  (alu_data),
        .lsu_valid_i (lsu_valid),
        .lsu_ready_o (lsu_ready),
        .lsu_rd_i    (lsu_rd),
        .lsu_data_i  (lsu_data),
        .set_en_i    (set_en),
        .set_rd_i    (set_rd),
        .rf_wr_en_o  (rf_wr_en),
        .rf_wrd_o    (rf_wrd),
        .rf_wdata_o  (rf_wdata),
        .pending_o   (pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_next;      // requester that wins the next contest
    bit          m_wr_en;
    bit [4:0]    m_wrd;
    bit [31:0]   m_wdata;
    bit [31:0]   m_pend;
    int          last_win;    // -1 none, 0 alu, 1 lsu

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next = 0; m_wr_en = 0; m_wrd = 0; m_wdata = 0; m_pend = 0; last_win = -1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; lsu_valid = 0; set_en = 0;
        alu_rd = 0; lsu_rd = 0; set_rd = 0; alu_data = 0; lsu_data = 0;
    endtask

    // Called at posedge+1 with inputs driven; returns at the following posedge+1.
    task automatic tick();
        int win;
        #3;
        win = -1;
        if (alu_valid && lsu_valid) win = m_next;
        else if (alu_valid)         win = 0;
        else if (lsu_valid)         win = 1;
        chk("alu_ready", 64'(alu_ready), 64'(win == 0));
        chk("lsu_ready", 64'(lsu_ready), 64'(win == 1));
        last_win = win;
        @(posedge clk);
        if (m_wr_en) m_pend[m_wrd] = 1'b0;
        if (set_en && set_rd != 0) m_pend[set_rd] = 1'b1;
        if (win >= 0) begin
            m_next  = 1 - win;
            m_wrd   = (win == 0) ? alu_rd : lsu_rd;
            m_wdata = (win == 0) ? alu_data : lsu_data;
            m_wr_en = (m_wrd != 0);
        end else begin
            m_wr_en = 1'b0;
        end
        #1;
        chk("rf_wr_en", 64'(rf_wr_en), 64'(m_wr_en));
        chk("rf_wrd",   64'(rf_wrd),   64'(m_wrd));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("pending",  64'(pending),  64'(m_pend));
    endtask

    initial begin
        int wrd_seq[4];
        int ai, li, n;
        bit [4:0] want_seq[4] = '{5'd1, 5'd11, 5'd2, 5'd12};

        rst_n = 0;
        idle_inputs();
        model_reset();
        alu_valid = 1; lsu_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("rst_wr_en",     64'(rf_wr_en),  64'd0);
        chk("rst_wrd",       64'(rf_wrd),    64'd0);
        chk("rst_wdata",     64'(rf_wdata),  64'd0);
        chk("rst_pending",   64'(pending),   64'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Idle cycles
        repeat (2) tick();

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        chk("alu5_wr_en", 64'(rf_wr_en), 64'd1);
        chk("alu5_wrd",   64'(rf_wrd),   64'd5);
        chk("alu5_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        tick();

        // LSU write to x0: handshake completes, no register-file write
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        tick();
        idle_inputs();
        chk("x0_wr_en", 64'(rf_wr_en), 64'd0);
        chk("x0_wdata", 64'(rf_wdata), 64'h1234);
        set_en = 1; set_rd = 0;
        tick();
        idle_inputs();
        chk("x0_pending", 64'(pending), 64'd0);

        // Contention: each requester holds until accepted
        ai = 0; li = 0; n = 0;
        repeat (4) begin
            alu_valid = 1; alu_rd = 5'(1 + ai);  alu_data = 32'(32'hA000 + ai);
            lsu_valid = 1; lsu_rd = 5'(11 + li); lsu_data = 32'(32'hB000 + li);
            tick();
            wrd_seq[n] = int'(rf_wrd);
            n++;
            if (last_win == 0) ai++; else if (last_win == 1) li++;
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) chk("contend_wrd", 64'(wrd_seq[i]), 64'(want_seq[i]));
        tick();

        // Pending set then cleared by the matching write
        set_en = 1; set_rd = 7;
        tick();
        idle_inputs();
        chk("p7_set", 64'(pending[7]), 64'd1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        tick();
        idle_inputs();
        tick();
        chk("p7_clear", 64'(pending[7]), 64'd0);

        // Set coinciding with the clearing write: set wins
        set_en = 1; set_rd = 7;
        tick();
        idle_inputs();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        tick();
        idle_inputs();
        set_en = 1; set_rd = 7;
        tick();
        idle_inputs();
        chk("p7_set_wins", 64'(pending[7]), 64'd1);
        tick();

        // Reset in the cycle after an ALU handshake to x9
        set_en = 1; set_rd = 9;
        tick();
        idle_inputs();
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        tick();
        chk("pre_rst_wr_en", 64'(rf_wr_en), 64'd1);
        alu_valid = 1; lsu_valid = 1;
        rst_n = 0;
        model_reset();
        #1;
        chk("mid_rst_wr_en",   64'(rf_wr_en),  64'd0);
        chk("mid_rst_pending", 64'(pending),   64'd0);
        chk("mid_rst_alu_rdy", 64'(alu_ready), 64'd0);
        chk("mid_rst_lsu_rdy", 64'(lsu_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        alu_rd = 3; lsu_rd = 4; alu_data = 32'h3; lsu_data = 32'h4;
        tick();
        chk("post_rst_first", 64'(last_win), 64'd0);
        idle_inputs();
        tick();

        // Randomized traffic; a request that was not accepted is held unchanged
        repeat (400) begin
            if (!alu_valid || last_win == 0) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!lsu_valid || last_win == 1) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd    = 5'($urandom);
                lsu_data  = $urandom;
            end
            set_en = ($urandom_range(0, 3) == 0);
            set_rd = 5'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
